// File: rtl/ref_bank_array.sv
// Banked reference-window buffer: rotating-burst write sequencer plus a one-cycle random-access read port.
// Optional macro REF_BANK_BYPASS_EN selects write-first forwarding for same-word read-during-write.
module ref_bank_array #(
  parameter int PIXEL        = 8,
  parameter int PIX_PER_WORD = 8,
  parameter int DEPTH        = 96,
  parameter int NUM_BANKS    = 4,
  parameter int BURST_LEN    = 24,
  localparam int W    = PIXEL * PIX_PER_WORD,
  localparam int AW   = $clog2(DEPTH),
  localparam int BW   = $clog2(NUM_BANKS),
  localparam int NSEG = DEPTH / BURST_LEN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [W-1:0]  wr_data,
  output logic [BW-1:0] wr_bank,
  output logic [AW-1:0] wr_addr,
  output logic          round_done,
  input  logic          rd_en,
  input  logic [BW-1:0] rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic          rd_err
);

  localparam logic [AW-1:0] LAST_WORD     = AW'(BURST_LEN - 1);
  localparam logic [BW-1:0] LAST_BANK     = BW'(NUM_BANKS - 1);
  localparam logic [AW-1:0] LAST_SEG_BASE = AW'((NSEG - 1) * BURST_LEN);
  localparam logic [AW-1:0] SEG_STEP      = AW'(BURST_LEN);

  logic [AW-1:0] word_cnt;
  logic [BW-1:0] bank_cnt;
  // seg_base carries seg_cnt*BURST_LEN directly so the address needs no multiplier
  logic [AW-1:0] seg_base;
  logic          wr_fire;
  logic          last_word;
  logic          last_bank;
  logic          last_seg;

  assign wr_fire   = wr_valid & wr_ready;
  assign last_word = (word_cnt == LAST_WORD);
  assign last_bank = (bank_cnt == LAST_BANK);
  assign last_seg  = (seg_base == LAST_SEG_BASE);
  assign wr_bank   = bank_cnt;
  assign wr_addr   = seg_base + word_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ready   <= 1'b0;
      word_cnt   <= '0;
      bank_cnt   <= '0;
      seg_base   <= '0;
      round_done <= 1'b0;
    end else begin
      wr_ready   <= 1'b1;
      round_done <= wr_fire & last_word & last_bank & last_seg;
      if (wr_fire) begin
        if (!last_word) begin
          word_cnt <= word_cnt + 1'b1;
        end else begin
          word_cnt <= '0;
          if (!last_bank) begin
            bank_cnt <= bank_cnt + 1'b1;
          end else begin
            bank_cnt <= '0;
            seg_base <= last_seg ? '0 : seg_base + SEG_STEP;
          end
        end
      end
    end
  end

  // Bank storage: contents survive reset
  logic [W-1:0] mem [NUM_BANKS][DEPTH];

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[bank_cnt][wr_addr] <= wr_data;
    end
  end

  // Stage p0: range check and array read
  logic          rd_oor_p0;
  logic [W-1:0]  rd_word_p0;

  assign rd_oor_p0 = (32'(rd_bank) >= 32'(NUM_BANKS)) || (32'(rd_addr) >= 32'(DEPTH));

  always_comb begin
    rd_word_p0 = '0;
    if (rd_en && !rd_oor_p0) begin
`ifdef REF_BANK_BYPASS_EN
      if (wr_fire && (bank_cnt == rd_bank) && (wr_addr == rd_addr)) begin
        rd_word_p0 = wr_data;
      end else begin
        rd_word_p0 = mem[rd_bank][rd_addr];
      end
`else
      rd_word_p0 = mem[rd_bank][rd_addr];
`endif
    end
  end

  // Stage p1: registered read result
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en & rd_oor_p0;
      if (rd_en) begin
        rd_data <= rd_word_p0;
      end
    end
  end

endmodule

// File: tb/tb_ref_bank_array.sv
// Bench for ref_bank_array: reference model of the write rotation, read scoreboard queue,
// constant vector tables and directed reset / read-during-write / out-of-range sequences.
module tb_ref_bank_array;
  localparam int W     = 64;
  localparam int AW    = 7;
  localparam int BW    = 2;
  localparam int DEPTH = 96;
  localparam int NB    = 4;
  localparam int BL    = 24;
  localparam int ROUND = DEPTH * NB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wr_valid, wr_ready, round_done, rd_en, rd_valid, rd_err;
  logic [W-1:0]  wr_data, rd_data;
  logic [BW-1:0] wr_bank, rd_bank;
  logic [AW-1:0] wr_addr, rd_addr;

  ref_bank_array dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_bank(wr_bank), .wr_addr(wr_addr), .round_done(round_done), .rd_en(rd_en),
    .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err)
  );

  // Small three-bank instance so an out-of-range bank index is expressible
  logic       s_wr_valid, s_wr_ready, s_round_done, s_rd_en, s_rd_valid, s_rd_err;
  logic [7:0] s_wr_data, s_rd_data;
  logic [1:0] s_wr_bank, s_rd_bank;
  logic [2:0] s_wr_addr, s_rd_addr;

  ref_bank_array #(.PIXEL(8), .PIX_PER_WORD(1), .DEPTH(8), .NUM_BANKS(3), .BURST_LEN(4)) dut_small (
    .clk(clk), .rst(rst), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wr_data(s_wr_data),
    .wr_bank(s_wr_bank), .wr_addr(s_wr_addr), .round_done(s_round_done), .rd_en(s_rd_en),
    .rd_bank(s_rd_bank), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .rd_err(s_rd_err)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           due;
  } exp_t;

  typedef struct {
    logic [BW-1:0] bank;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          err;
  } vec_t;

  exp_t         sbq[$];
  logic [W-1:0] mem_m [NB][DEPTH];
  int           wr_idx;
  int           cyc;
  int           errors;
  int           checks;
  logic         exp_done;
  logic [W-1:0] pat_55, pat_aa, exp_rdw;
  vec_t         tab1 [10];
  vec_t         tab2 [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int exp_bank(input int i);
    int r;
    r = i % ROUND;
    return (r / BL) % NB;
  endfunction

  function automatic int exp_addr(input int i);
    int r;
    r = i % ROUND;
    return (r / (BL * NB)) * BL + (r % BL);
  endfunction

  function automatic logic [W-1:0] model_rd(input int b, input int a, input bit hit, input logic [W-1:0] wd);
    if (a >= DEPTH || b >= NB) return '0;
`ifdef REF_BANK_BYPASS_EN
    if (hit) return wd;
`endif
    return mem_m[b][a];
  endfunction

  // One clock: outputs sampled 1 time unit after the edge, scoreboard front compared when due
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("rd_valid", 64'(rd_valid), 64'd1);
      chk("rd_data", rd_data, e.data);
      chk("rd_err", 64'(rd_err), 64'(e.err));
    end else begin
      chk("rd_valid_idle", 64'(rd_valid), 64'd0);
    end
    chk("round_done", 64'(round_done), 64'(exp_done));
  endtask

  task automatic cycle_io(input bit do_wr, input logic [W-1:0] wd, input bit do_rd,
                          input logic [BW-1:0] rb, input logic [AW-1:0] ra,
                          input logic [W-1:0] xd, input logic xe);
    exp_t e;
    wr_valid = do_wr;
    wr_data  = wd;
    rd_en    = do_rd;
    rd_bank  = rb;
    rd_addr  = ra;
    exp_done = 1'b0;
    if (do_rd) begin
      e.data = xd;
      e.err  = xe;
      e.due  = cyc + 1;
      sbq.push_back(e);
    end
    if (do_wr) begin
      chk("wr_bank", 64'(wr_bank), 64'(exp_bank(wr_idx)));
      chk("wr_addr", 64'(wr_addr), 64'(exp_addr(wr_idx)));
      mem_m[exp_bank(wr_idx)][exp_addr(wr_idx)] = wd;
      exp_done = ((wr_idx % ROUND) == ROUND - 1);
      wr_idx++;
    end
    step();
  endtask

  task automatic wr(input logic [W-1:0] wd);
    cycle_io(1'b1, wd, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic rd(input int b, input int a);
    logic oor;
    oor = (a >= DEPTH) || (b >= NB);
    cycle_io(1'b0, '0, 1'b1, BW'(b), AW'(a), model_rd(b, a, 1'b0, '0), oor);
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    exp_done = 1'b0;
    step();
  endtask

  task automatic do_reset(input bit with_rd);
    sbq.delete();
    rst      = 1'b1;
    wr_valid = 1'b0;
    rd_en    = with_rd;
    rd_bank  = 2'd1;
    rd_addr  = '0;
    exp_done = 1'b0;
    step();
    chk("wr_ready_rst", 64'(wr_ready), 64'd0);
    chk("wr_bank_rst", 64'(wr_bank), 64'd0);
    chk("wr_addr_rst", 64'(wr_addr), 64'd0);
    chk("rd_data_rst", rd_data, 64'd0);
    chk("rd_err_rst", 64'(rd_err), 64'd0);
    rd_en = 1'b0;
    step();
    rst    = 1'b0;
    wr_idx = 0;
    step();
    chk("wr_ready_run", 64'(wr_ready), 64'd1);
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; wr_idx = 0; exp_done = 1'b0;
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_en = 1'b0; rd_bank = '0; rd_addr = '0;
    s_wr_valid = 1'b0; s_wr_data = '0; s_rd_en = 1'b0; s_rd_bank = '0; s_rd_addr = '0;
    pat_55 = {(W/8){8'h55}};
    pat_aa = {(W/8){8'haa}};
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) mem_m[b][a] = '0;

    tab1[0] = '{2'd0, 7'd0,   64'd0,   1'b0};
    tab1[1] = '{2'd0, 7'd23,  64'd23,  1'b0};
    tab1[2] = '{2'd1, 7'd0,   64'd24,  1'b0};
    tab1[3] = '{2'd1, 7'd23,  64'd47,  1'b0};
    tab1[4] = '{2'd0, 7'd24,  64'd96,  1'b0};
    tab1[5] = '{2'd2, 7'd30,  64'd150, 1'b0};
    tab1[6] = '{2'd3, 7'd95,  64'd383, 1'b0};
    tab1[7] = '{2'd0, 7'd96,  64'd0,   1'b1};
    tab1[8] = '{2'd3, 7'd127, 64'd0,   1'b1};
    tab1[9] = '{2'd1, 7'd23,  64'd47,  1'b0};
    tab2[0] = '{2'd2, 7'd30,  64'd1150, 1'b0};
    tab2[1] = '{2'd0, 7'd0,   64'd1000, 1'b0};
    tab2[2] = '{2'd3, 7'd95,  64'd1383, 1'b0};
    tab2[3] = '{2'd1, 7'd100, 64'd0,    1'b1};

    do_reset(1'b0);

    // First round: data = index
    for (int i = 0; i < ROUND; i++) wr(W'(i));
    chk("wrap_bank", 64'(wr_bank), 64'd0);
    chk("wrap_addr", 64'(wr_addr), 64'd0);

    for (int k = 0; k < 10; k++)
      cycle_io(1'b0, '0, 1'b1, tab1[k].bank, tab1[k].addr, tab1[k].data, tab1[k].err);
    idle();
    chk("rd_hold", rd_data, 64'd47);

    // Second round overwrites the window
    for (int i = 0; i < ROUND; i++) wr(W'(1000 + i));
    for (int k = 0; k < 4; k++)
      cycle_io(1'b0, '0, 1'b1, tab2[k].bank, tab2[k].addr, tab2[k].data, tab2[k].err);
    idle();

    // Back-to-back reads on alternating banks
    for (int k = 0; k < 10; k++) rd(k % 2, (k * 7 + 3) % DEPTH);
    idle();

    // Reset after 30 words; the read issued with reset must be dropped
    do_reset(1'b0);
    for (int i = 0; i < 29; i++) wr(W'(5000 + i));
    wr(pat_55);
    idle();
    do_reset(1'b1);
    for (int a = 0; a < 6; a++) rd(1, a);
    idle();

    // Read-during-write on bank1 addr5
    for (int i = 0; i < 29; i++) wr(W'(7000 + i));
`ifdef REF_BANK_BYPASS_EN
    exp_rdw = pat_aa;
`else
    exp_rdw = pat_55;
`endif
    cycle_io(1'b1, pat_aa, 1'b1, 2'd1, 7'd5, exp_rdw, 1'b0);
    rd(1, 5);
    idle();

    // Three-bank instance: fill one segment of every bank, then read in and out of range
    for (int i = 0; i < 12; i++) begin
      s_wr_valid = 1'b1;
      s_wr_data  = 8'(i);
      idle();
    end
    s_wr_valid = 1'b0;
    chk("s_wr_bank", 64'(s_wr_bank), 64'd0);
    chk("s_wr_addr", 64'(s_wr_addr), 64'd4);
    s_rd_en = 1'b1; s_rd_bank = 2'd2; s_rd_addr = 3'd1;
    idle();
    chk("s_rd_valid", 64'(s_rd_valid), 64'd1);
    chk("s_rd_data", 64'(s_rd_data), 64'd9);
    chk("s_rd_err", 64'(s_rd_err), 64'd0);
    s_rd_bank = 2'd3; s_rd_addr = 3'd0;
    idle();
    chk("s_oor_valid", 64'(s_rd_valid), 64'd1);
    chk("s_oor_data", 64'(s_rd_data), 64'd0);
    chk("s_oor_err", 64'(s_rd_err), 64'd1);
    s_rd_en = 1'b0;
    idle();
    chk("s_idle_valid", 64'(s_rd_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
